ds_adc_conv_ctrl: RTL and testbench

Conversion sequencer for the delta-sigma ADC digital back-end. It runs in the oversampling clock domain and counts comparator ones over a programmable decimation window. It discards a programmable number of settling windows after start, then applies offset correction with saturation. Each result is delivered on a valid/ready handshake, in single-shot or continuous mode, with overrun detection.

---
 rtl/ds_adc_conv_ctrl_if.sv | 27 ++
 rtl/ds_adc_conv_ctrl.sv | 115 +++++++++++
 tb/tb_ds_adc_conv_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ds_adc_conv_ctrl_if.sv
// Conversion control / result handshake bundle for ds_adc_conv_ctrl.
// The master side drives control, bitstream and ready; the slave side is the sequencer.
interface ds_adc_conv_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int OSR_W = 8
);
    logic             start;
    logic             cont;
    logic [OSR_W-1:0] osr;
    logic [WIDTH-1:0] offset;
    logic             comp_out;
    logic             busy;
    logic [WIDTH-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             overrun;

    modport master (
        output start, cont, osr, offset, comp_out, res_ready,
        input  busy, res_data, res_valid, overrun
    );

    modport slave (
        input  start, cont, osr, offset, comp_out, res_ready,
        output busy, res_data, res_valid, overrun
    );
endinterface

// File: rtl/ds_adc_conv_ctrl.sv
// Delta-sigma ADC conversion sequencer: settle windows, ones counting per window,
// offset correction with saturation, valid/ready result delivery with overrun flag.
module ds_adc_conv_ctrl #(
    parameter int WIDTH  = 8,
    parameter int OSR_W  = 8,
    parameter int SETTLE = 2
) (
    input logic              clk,
    input logic              rst,
    ds_adc_conv_ctrl_if.slave bus
);
    localparam int DW = WIDTH + OSR_W + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic signed [DW-1:0] SMAX = {{(OSR_W+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {{(OSR_W+2){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM} state_t;

    state_t           state_q, state_d;
    logic [OSR_W-1:0] osr_q;
    logic [WIDTH-1:0] offset_q;
    logic [OSR_W-1:0] samp_cnt;
    logic [OSR_W-1:0] ones_cnt;
    logic [SW-1:0]    win_cnt;
    logic [WIDTH-1:0] res_data_q;
    logic             res_valid_q;
    logic             overrun_q;

    logic             win_end, settle_done, start_acc, load;
    logic [OSR_W-1:0] ones_fin;
    logic signed [DW-1:0] ones_ext, off_ext, diff;
    logic [WIDTH-1:0] sat_val;

    always_comb begin
        win_end     = (samp_cnt == osr_q - OSR_W'(1));
        settle_done = win_end && (win_cnt == SW'(SETTLE - 1));
        state_d     = state_q;
        start_acc   = 1'b0;
        load        = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                start_acc = 1'b1;
                state_d   = (SETTLE > 0) ? S_SETTLE : S_ACCUM;
            end
            S_SETTLE: if (settle_done) state_d = S_ACCUM;
            S_ACCUM: if (win_end) begin
                load    = 1'b1;
                state_d = bus.cont ? S_ACCUM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // The final sample is folded in combinationally so the result loads on its own edge.
    always_comb begin
        ones_fin = ones_cnt + OSR_W'(bus.comp_out);
        ones_ext = {{(WIDTH+1){1'b0}}, ones_fin};
        off_ext  = {{(OSR_W+1){offset_q[WIDTH-1]}}, offset_q};
        diff     = ones_ext - off_ext;
        if (diff > SMAX)      sat_val = SMAX[WIDTH-1:0];
        else if (diff < SMIN) sat_val = SMIN[WIDTH-1:0];
        else                  sat_val = diff[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osr_q       <= '0;
            offset_q    <= '0;
            samp_cnt    <= '0;
            ones_cnt    <= '0;
            win_cnt     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                osr_q     <= (bus.osr == '0) ? OSR_W'(1) : bus.osr;
                offset_q  <= bus.offset;
                overrun_q <= 1'b0;
                samp_cnt  <= '0;
                ones_cnt  <= '0;
                win_cnt   <= '0;
            end else if (state_q != S_IDLE) begin
                if (win_end) begin
                    samp_cnt <= '0;
                    ones_cnt <= '0;
                    if (state_q == S_SETTLE)
                        win_cnt <= settle_done ? '0 : win_cnt + SW'(1);
                end else begin
                    samp_cnt <= samp_cnt + OSR_W'(1);
                    if (state_q == S_ACCUM) ones_cnt <= ones_fin;
                end
            end

            // A load on the acceptance edge replaces the result cleanly; otherwise it clobbers it.
            if (load) begin
                res_data_q  <= sat_val;
                res_valid_q <= 1'b1;
                if (res_valid_q && !bus.res_ready) overrun_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_ds_adc_conv_ctrl.sv
// Randomized scoreboard bench for ds_adc_conv_ctrl with directed backpressure and reset cases.
module tb_ds_adc_conv_ctrl;
    localparam int WIDTH  = 8;
    localparam int OSR_W  = 8;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ds_adc_conv_ctrl_if #(.WIDTH(WIDTH), .OSR_W(OSR_W)) bus ();
    ds_adc_conv_ctrl #(.WIDTH(WIDTH), .OSR_W(OSR_W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   sb_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        int mx, mn;
        mx = (1 << (WIDTH - 1)) - 1;
        mn = -(1 << (WIDTH - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every valid&ready cycle with ready held high is one distinct result.
    always @(negedge clk) begin
        if (!rst && sb_on && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", int'($signed(bus.res_data)), e.data);
                chk("res_cycle", cyc, e.cyc);
            end
        end
    end

    // pat: 0 random, 1 all ones, 2 all zeros, 3 alternating starting with 1
    task automatic run_conv(input int n_in, input int off, input int k, input int pat, input bit spam);
        int n, total, busy_cnt;
        bit bits[$];
        n        = (n_in == 0) ? 1 : n_in;
        total    = (SETTLE + k) * n;
        busy_cnt = 0;
        for (int i = 0; i < total; i++) begin
            case (pat)
                0:       bits.push_back(1'($urandom_range(0, 1)));
                1:       bits.push_back(1'b1);
                2:       bits.push_back(1'b0);
                default: bits.push_back(i % 2 == 0);
            endcase
        end
        for (int w = 0; w < k; w++) begin
            int   ones;
            exp_t e;
            ones = 0;
            for (int i = (SETTLE + w) * n; i < (SETTLE + w + 1) * n; i++) ones += int'(bits[i]);
            e.data = sat(ones - off);
            e.cyc  = cyc + 1 + (SETTLE + w + 1) * n;
            exp_q.push_back(e);
        end
        bus.start    = 1'b1;
        bus.osr      = OSR_W'(n_in);
        bus.offset   = WIDTH'(off);
        bus.cont     = 1'b0;
        bus.comp_out = 1'($urandom_range(0, 1));
        tick();
        for (int t = 1; t <= total; t++) begin
            bus.start    = spam && (t < total) && ($urandom_range(0, 7) == 0);
            bus.osr      = OSR_W'($urandom);
            bus.offset   = WIDTH'($urandom);
            bus.comp_out = bits[t-1];
            bus.cont     = (t <= (SETTLE + k - 1) * n);
            busy_cnt    += int'(bus.busy);
            tick();
        end
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        chk("busy_cycles", busy_cnt, total);
        chk("idle_after", int'(bus.busy), 0);
        chk("no_overrun", int'(bus.overrun), 0);
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cont      = 1'b0;
        bus.osr       = '0;
        bus.offset    = '0;
        bus.comp_out  = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.res_valid), 0);
        chk("rst_data", int'(bus.res_data), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        rst   = 1'b0;
        sb_on = 1'b1;
        tick();

        run_conv(10, 5, 1, 1, 1'b0);
        run_conv(16, 8, 4, 3, 1'b0);
        run_conv(255, -128, 1, 1, 1'b0);
        run_conv(255, 127, 1, 2, 1'b0);
        run_conv(0, 3, 5, 0, 1'b0);
        run_conv(0, -1, 3, 1, 1'b1);
        run_conv(6, -20, 2, 0, 1'b1);
        for (int r = 0; r < 20; r++)
            run_conv($urandom_range(0, 12), int'($urandom_range(0, 255)) - 128,
                     $urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // Backpressure: two results, second overwrites the first.
        sb_on         = 1'b0;
        bus.res_ready = 1'b0;
        bus.start     = 1'b1;
        bus.osr       = 8'd4;
        bus.offset    = 8'd1;
        bus.cont      = 1'b1;
        bus.comp_out  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            bus.comp_out = (t <= 12);
            bus.cont     = (t <= 12);
            tick();
            if (t == 12) begin
                chk("bp_first_valid", int'(bus.res_valid), 1);
                chk("bp_first_data", int'($signed(bus.res_data)), 3);
                chk("bp_first_overrun", int'(bus.overrun), 0);
            end
            if (t == 15) begin
                chk("bp_stable_valid", int'(bus.res_valid), 1);
                chk("bp_stable_data", int'($signed(bus.res_data)), 3);
            end
        end
        chk("bp_second_data", int'($signed(bus.res_data)), -1);
        chk("bp_second_valid", int'(bus.res_valid), 1);
        chk("bp_overrun_set", int'(bus.overrun), 1);
        chk("bp_idle", int'(bus.busy), 0);
        bus.res_ready = 1'b1;
        tick();
        chk("bp_accept_clears", int'(bus.res_valid), 0);
        chk("bp_overrun_sticky", int'(bus.overrun), 1);
        bus.res_ready = 1'b0;
        bus.start     = 1'b1;
        bus.osr       = 8'd1;
        bus.offset    = 8'd0;
        bus.cont      = 1'b0;
        tick();
        bus.start = 1'b0;
        chk("bp_start_clears_overrun", int'(bus.overrun), 0);
        chk("bp_start_busy", int'(bus.busy), 1);
        repeat (5) tick();
        bus.res_ready = 1'b1;
        repeat (2) tick();

        // Reset mid-ACCUM must abort with no result.
        sb_on        = 1'b1;
        bus.start    = 1'b1;
        bus.osr      = 8'd4;
        bus.offset   = 8'd0;
        bus.comp_out = 1'b1;
        bus.cont     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_valid", int'(bus.res_valid), 0);
        chk("mid_rst_overrun", int'(bus.overrun), 0);
        bus.start = 1'b1;
        tick();
        chk("rst_beats_start", int'(bus.busy), 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (20) tick();
        chk("cont_alone_no_start", int'(bus.busy), 0);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
